// File: rtl/motor_dir_sequencer.sv
// H-bridge direction sequencer for one DC motor: PWM generation, leg steering,
// and a forced both-legs-off dead time on every direction change.
module motor_dir_sequencer #(
  parameter int unsigned PWM_WIDTH = 8,
  parameter int unsigned DEADTIME  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 dir_req,
  input  logic [PWM_WIDTH-1:0] duty,
  output logic [1:0]           out,
  output logic                 dir_active,
  output logic                 busy,
  output logic                 pwm
);

  localparam int unsigned DT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DT_W-1:0]      DT_LOAD = DT_W'(DEADTIME - 1);
  localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 dir_q, dir_d;
  logic [DT_W-1:0]      dt_q, dt_d;
  logic [PWM_WIDTH-1:0] cnt_q;
  logic [PWM_WIDTH-1:0] cur_duty_q;
  logic                 pwm_q;

  // Free-running PWM; duty is only taken at the period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      cur_duty_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      cnt_q <= cnt_q + PWM_WIDTH'(1);
      if (cnt_q == CNT_MAX) begin
        cur_duty_q <= duty;
      end
      pwm_q <= (cnt_q < cur_duty_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      dt_q    <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      dt_q    <= dt_d;
    end
  end

  // Direction is only ever committed at dead-time expiry.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    dt_d    = dt_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (dir_req != dir_q) begin
            state_d = DEAD;
            dt_d    = DT_LOAD;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (dir_req != dir_q) begin
          state_d = DEAD;
          dt_d    = DT_LOAD;
        end
      end
      DEAD: begin
        if (dt_q == '0) begin
          dir_d   = dir_req;
          state_d = en ? RUN : IDLE;
        end else begin
          dt_d = dt_q - DT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Only one leg can ever carry pwm, so 2'b11 is unreachable.
  always_comb begin
    out = 2'b00;
    if (state_q == RUN) begin
      out = dir_q ? {pwm_q, 1'b0} : {1'b0, pwm_q};
    end
  end

  assign dir_active = dir_q;
  assign busy       = (state_q == DEAD);
  assign pwm        = pwm_q;

endmodule

// File: tb/tb_motor_dir_sequencer.sv
// Scoreboard bench for motor_dir_sequencer (PWM_WIDTH=4, DEADTIME=3).
module tb_motor_dir_sequencer;

  localparam int unsigned PW     = 4;
  localparam int unsigned DT     = 3;
  localparam int          PERIOD = 16;
  localparam int          S_IDLE = 0;
  localparam int          S_RUN  = 1;
  localparam int          S_DEAD = 2;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          dir_req;
  logic [PW-1:0] duty;
  logic [1:0]    out;
  logic          dir_active;
  logic          busy;
  logic          pwm;

  motor_dir_sequencer #(
    .PWM_WIDTH(PW),
    .DEADTIME (DT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .dir_req   (dir_req),
    .duty      (duty),
    .out       (out),
    .dir_active(dir_active),
    .busy      (busy),
    .pwm       (pwm)
  );

  typedef struct {
    int         key;
    logic [1:0] out;
    logic       busy;
    logic       da;
    logic       pwm;
    int         tid;
  } exp_t;

  exp_t sb[$];
  int   n;
  int   cd;
  int   tid;
  int   n_checks;
  int   n_fail;
  exp_t mon_x;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; edge k sees PWM counter value k mod 16.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s test=%0d edge=%0d actual=%0d required=%0d", name, tid, n, act, exp_v);
    end
  endtask

  // Drive inputs for the next edge and queue the response expected after it.
  task automatic drive(input logic e, input logic d, input int du, input int st, input logic da);
    exp_t x;
    logic p;
    en      = e;
    dir_req = d;
    duty    = PW'(du);
    p = ((n % PERIOD) < cd);
    if ((n % PERIOD) == PERIOD - 1) cd = du;
    x.key  = n + 1;
    x.pwm  = p;
    x.busy = (st == S_DEAD);
    x.da   = da;
    x.out  = (st == S_RUN) ? (da ? {p, 1'b0} : {1'b0, p}) : 2'b00;
    x.tid  = tid;
    sb.push_back(x);
    @(negedge clk);
  endtask

  task automatic drive_n(input int cnt, input logic e, input logic d, input int du,
                         input int st, input logic da);
    for (int i = 0; i < cnt; i++) drive(e, d, du, st, da);
  endtask

  // Monitor: compares every queued expectation whose edge has occurred.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_not_11", int'(out == 2'b11), 0);
      while (sb.size() > 0 && sb[0].key <= n) begin
        mon_x = sb.pop_front();
        if (mon_x.key < n) begin
          chk("missed_sample", mon_x.key, n);
        end else begin
          chk("out",        int'(out),        int'(mon_x.out));
          chk("busy",       int'(busy),       int'(mon_x.busy));
          chk("dir_active", int'(dir_active), int'(mon_x.da));
          chk("pwm",        int'(pwm),        int'(mon_x.pwm));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cd       = 0;
    tid      = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    dir_req  = 1'b0;
    duty     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out",  int'(out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dir",  int'(dir_active), 0);
    chk("rst_pwm",  int'(pwm), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: forward run, duty 4 latched at first wrap
    tid = 1;
    drive_n(48, 1'b1, 1'b0, 4, S_RUN, 1'b0);

    // 2: direction change forward -> reverse
    tid = 2;
    drive_n(2,  1'b1, 1'b0, 4, S_RUN,  1'b0);
    drive_n(3,  1'b1, 1'b1, 4, S_DEAD, 1'b0);
    drive_n(27, 1'b1, 1'b1, 4, S_RUN,  1'b1);

    // 3: mid-period duty changes to 0 then 15
    tid = 3;
    drive_n(2,  1'b1, 1'b1, 4,  S_RUN, 1'b1);
    drive_n(14, 1'b1, 1'b1, 0,  S_RUN, 1'b1);
    drive_n(22, 1'b1, 1'b1, 0,  S_RUN, 1'b1);
    drive_n(10, 1'b1, 1'b1, 15, S_RUN, 1'b1);
    drive_n(16, 1'b1, 1'b1, 15, S_RUN, 1'b1);

    // 4: en dropped on second dead clock
    tid = 4;
    drive_n(16, 1'b1, 1'b1, 4, S_RUN,  1'b1);
    drive  (    1'b1, 1'b0, 4, S_DEAD, 1'b1);
    drive_n(2,  1'b0, 1'b0, 4, S_DEAD, 1'b1);
    drive_n(5,  1'b0, 1'b0, 4, S_IDLE, 1'b0);

    // 5: dir_req toggles back during dead time
    tid = 5;
    drive  (    1'b1, 1'b1, 4, S_DEAD, 1'b0);
    drive_n(2,  1'b1, 1'b0, 4, S_DEAD, 1'b0);
    drive_n(21, 1'b1, 1'b0, 4, S_RUN,  1'b0);

    // 6: asynchronous reset while out[0] is high
    tid = 6;
    drive_n(2, 1'b1, 1'b0, 4, S_RUN, 1'b0);
    chk("pre_rst_out", int'(out), 1);
    #2;
    rst_n = 1'b0;
    cd    = 0;
    #1;
    chk("async_rst_out",  int'(out), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_dir",  int'(dir_active), 0);
    chk("async_rst_pwm",  int'(pwm), 0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_n(3,  1'b0, 1'b0, 4, S_IDLE, 1'b0);
    drive_n(29, 1'b1, 1'b0, 4, S_RUN,  1'b0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
